// File: rtl/core_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : core_pkg
//  Description : Shared core types and constants for the fetch front end.
//  Revision    : 1.0 - initial release
// ============================================================================
package core_pkg;

    localparam int XLEN = 32;

    // Clears the byte-offset bits of a word address
    localparam logic [XLEN-1:0] INST_ALIGN_MASK = 32'hffff_fffc;

    // One queued instruction: its fetch PC and the fetched word
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
    } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/inst_queue.sv
`default_nettype none
// ============================================================================
//  Module      : inst_queue
//  Description : Synchronous in-order FIFO with push, pop, flush, an
//                occupancy count and a register-sourced head entry.
//  Revision    : 1.0 - initial release
// ============================================================================
module inst_queue
    import core_pkg::*;
#(
    parameter int  DEPTH   = 4,
    parameter type ENTRY_T = fetch_entry_t,
    localparam int CW      = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  ENTRY_T        push_data,
    input  logic          pop,
    input  logic          flush,
    output logic [CW-1:0] count,
    output logic          head_valid,
    output ENTRY_T        head
);

    localparam int PW = $clog2(DEPTH);

    ENTRY_T          mem [DEPTH];
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;
    logic            do_push;
    logic            do_pop;

    // A push into a full queue is only legal when the head leaves the same edge
    assign do_pop     = pop && (count != '0);
    assign do_push    = push && ((count != CW'(DEPTH)) || do_pop);
    assign head_valid = (count != '0);
    assign head       = mem[rd_ptr];

    // Pointer and occupancy bookkeeping; flush discards every entry
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    // Entry storage; cleared on reset so the head reads as zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (do_push && !flush) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/inst_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : inst_fetch
//  Description : Instruction-fetch front end. Issues sequential word fetches
//                under a credit limit, queues responses in order for decode,
//                and redirects on jumps by flushing the queue and dropping
//                stale in-flight responses.
//                Optional macro INST_FETCH_BYPASS_EN: a response arriving at
//                an empty queue is forwarded to decode in the same cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module inst_fetch
    import core_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        RST,
    output logic        INST_RDEN,
    output logic [31:0] INST_RADDR,
    input  logic        MEM_WAIT,
    input  logic        INST_RVALID,
    input  logic [31:0] INST_RDATA,
    input  logic        JMP_DO,
    input  logic [31:0] JMP_PC,
    output logic        INST_VALID,
    output logic [31:0] INST_PC,
    output logic [31:0] INST_DATA,
    input  logic        INST_READY
);

    localparam int CW = $clog2(DEPTH + 1);

    logic [CW-1:0]  count;
    logic [CW-1:0]  outstanding;
    logic [CW-1:0]  drop_cnt;
    logic [CW:0]    inflight_total;
    logic           reset_hold;
    logic           credit_ok;
    logic           accept;
    logic           resp_keep;
    logic           push;
    logic           pop;
    logic           q_valid;
    logic [31:0]    resp_pc;
    logic [31:0]    jmp_target;
    fetch_entry_t   q_head;
    fetch_entry_t   push_entry;

    // Queued entries plus requests still in flight may never exceed DEPTH
    assign inflight_total = {1'b0, count} + {1'b0, outstanding};
    assign credit_ok      = inflight_total < (CW+1)'(DEPTH);
    assign INST_RDEN      = credit_ok && !JMP_DO && !reset_hold;
    assign accept         = INST_RDEN && !MEM_WAIT;
    assign jmp_target     = JMP_PC & INST_ALIGN_MASK;

    // A response is kept only when no stale responses remain to be dropped
    assign resp_keep  = INST_RVALID && (drop_cnt == '0) && !JMP_DO;
    assign push_entry = '{pc: resp_pc, inst: INST_RDATA};
    assign pop        = q_valid && INST_READY && !JMP_DO;

`ifdef INST_FETCH_BYPASS_EN
    logic bypass;

    // Forward straight to decode when nothing older is waiting in the queue
    assign bypass     = resp_keep && !q_valid;
    assign push       = resp_keep && !(bypass && INST_READY);
    assign INST_VALID = bypass || (q_valid && !JMP_DO);
    assign INST_PC    = bypass ? resp_pc    : q_head.pc;
    assign INST_DATA  = bypass ? INST_RDATA : q_head.inst;
`else
    assign push       = resp_keep;
    assign INST_VALID = q_valid && !JMP_DO;
    assign INST_PC    = q_head.pc;
    assign INST_DATA  = q_head.inst;
`endif

    inst_queue #(
        .DEPTH   (DEPTH),
        .ENTRY_T (fetch_entry_t)
    ) u_queue (
        .clk        (CLK),
        .rst        (RST),
        .push       (push),
        .push_data  (push_entry),
        .pop        (pop),
        .flush      (JMP_DO),
        .count      (count),
        .head_valid (q_valid),
        .head       (q_head)
    );

    // Fetch PC, response PC, credit and stale-response tracking
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            reset_hold  <= 1'b1;
            INST_RADDR  <= RESET_PC & INST_ALIGN_MASK;
            resp_pc     <= RESET_PC & INST_ALIGN_MASK;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else begin
            reset_hold <= 1'b0;
            if (JMP_DO) begin
                INST_RADDR  <= jmp_target;
                resp_pc     <= jmp_target;
                outstanding <= outstanding - CW'(INST_RVALID);
                // Every request still in flight after this edge is stale.
                // outstanding already includes responses pending a drop, so
                // it alone is the drop total (keeps back-to-back jumps exact).
                drop_cnt    <= outstanding - CW'(INST_RVALID);
            end else begin
                if (accept)    INST_RADDR <= INST_RADDR + 32'd4;
                if (resp_keep) resp_pc    <= resp_pc + 32'd4;
                if (INST_RVALID && (drop_cnt != '0)) drop_cnt <= drop_cnt - CW'(1);
                outstanding <= outstanding + CW'(accept) - CW'(INST_RVALID);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_inst_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : tb_inst_fetch
//  Description : Scoreboard bench for inst_fetch with a variable-latency
//                in-order memory model and a second instance near the top
//                of the address space for PC wrap.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_inst_fetch;
    import core_pkg::*;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst, mem_wait, rvalid, jmp_do, ready;
    logic [31:0] rdata, jmp_pc;
    logic        rden, valid;
    logic [31:0] raddr, pc, data;

    logic        hi_rden, hi_rvalid, hi_valid, hi_req;
    logic [31:0] hi_raddr, hi_rdata, hi_pc, hi_data, hi_addr;

    always #5 clk = ~clk;

    inst_fetch #(.DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) u_dut (
        .CLK(clk), .RST(rst), .INST_RDEN(rden), .INST_RADDR(raddr),
        .MEM_WAIT(mem_wait), .INST_RVALID(rvalid), .INST_RDATA(rdata),
        .JMP_DO(jmp_do), .JMP_PC(jmp_pc), .INST_VALID(valid),
        .INST_PC(pc), .INST_DATA(data), .INST_READY(ready)
    );

    inst_fetch #(.DEPTH(DEPTH), .RESET_PC(32'hffff_fff8)) u_dut_wrap (
        .CLK(clk), .RST(rst), .INST_RDEN(hi_rden), .INST_RADDR(hi_raddr),
        .MEM_WAIT(1'b0), .INST_RVALID(hi_rvalid), .INST_RDATA(hi_rdata),
        .JMP_DO(1'b0), .JMP_PC(32'h0), .INST_VALID(hi_valid),
        .INST_PC(hi_pc), .INST_DATA(hi_data), .INST_READY(1'b1)
    );

    typedef struct {
        logic [31:0] addr;
        int          due;
    } req_t;

    req_t          pend[$];
    fetch_entry_t  exp_q[$];
    fetch_entry_t  sb_e;
    logic [31:0]   pop_log[$];
    logic [31:0]   hi_log[$];
    logic [31:0]   exp_raddr = 32'h0;
    int            cyc = 0;
    int            lat = 1;
    int            acc_count = 0;
    int            checks = 0;
    int            errors = 0;

`ifdef INST_FETCH_BYPASS_EN
    localparam logic EXP_VALID_C3 = 1'b1;
`else
    localparam logic EXP_VALID_C3 = 1'b0;
`endif

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hdead_beef;
    endfunction

    function automatic logic [31:0] log_at(input int i);
        return (i < pop_log.size()) ? pop_log[i] : 32'hxxxx_xxxx;
    endfunction

    function automatic logic [31:0] hi_at(input int i);
        return (i < hi_log.size()) ? hi_log[i] : 32'hxxxx_xxxx;
    endfunction

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Scoreboard: push on accepted request, clear on redirect, compare on pop
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            pend.delete();
            exp_raddr = 32'h0;
        end else begin
            if (valid && ready) begin
                if (exp_q.size() == 0) begin
                    check_value("sb_underflow", 32'd1, 32'd0);
                end else begin
                    sb_e = exp_q.pop_front();
                    check_value("sb_pc", pc, sb_e.pc);
                    check_value("sb_data", data, sb_e.inst);
                end
                pop_log.push_back(pc);
            end
            if (jmp_do) begin
                exp_q.delete();
                exp_raddr = jmp_pc & 32'hffff_fffc;
            end
            if (rden && !mem_wait) begin
                check_value("raddr_seq", raddr, exp_raddr);
                exp_q.push_back('{pc: exp_raddr, inst: mem_word(exp_raddr)});
                pend.push_back('{addr: raddr, due: cyc + lat});
                exp_raddr = exp_raddr + 32'd4;
                acc_count++;
            end
        end
    end

    // Memory model: in-order responses, at least lat cycles after acceptance
    always @(posedge clk) begin
        cyc++;
        #1;
        if (!rst && pend.size() > 0 && pend[0].due <= cyc) begin
            rvalid = 1'b1;
            rdata  = mem_word(pend[0].addr);
            pend.delete(0);
        end else begin
            rvalid = 1'b0;
            rdata  = 32'h0;
        end
    end

    // Latency-1 memory and PC log for the wrap instance
    always @(negedge clk) begin
        hi_req  = !rst && hi_rden;
        hi_addr = hi_raddr;
        if (!rst && hi_valid && hi_log.size() < 3) hi_log.push_back(hi_pc);
    end

    always @(posedge clk) begin
        #1;
        hi_rvalid = hi_req && !rst;
        hi_rdata  = mem_word(hi_addr);
    end

    task automatic do_reset(input int l);
        @(posedge clk); #1;
        rst      = 1'b1;
        mem_wait = 1'b0;
        jmp_do   = 1'b0;
        lat      = l;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        pop_log.delete();
        acc_count = 0;
    endtask

    initial begin
        rst = 1'b1; mem_wait = 1'b0; jmp_do = 1'b0; jmp_pc = 32'h0; ready = 1'b1;
        rvalid = 1'b0; rdata = 32'h0; hi_req = 1'b0; hi_rvalid = 1'b0;
        hi_rdata = 32'h0; hi_addr = 32'h0;

        // Reset state
        repeat (2) @(negedge clk);
        check_value("rst_rden",     32'(rden),  32'd0);
        check_value("rst_raddr",    raddr,      32'h0);
        check_value("rst_valid",    32'(valid), 32'd0);
        check_value("rst_pc",       pc,         32'h0);
        check_value("rst_data",     data,       32'h0);
        check_value("rst_raddr_hi", hi_raddr,   32'hffff_fff8);

        // Streaming, latency 1, decode always ready
        ready = 1'b1;
        do_reset(1);
        @(negedge clk);
        check_value("rden_cycle1", 32'(rden), 32'd0);
        @(negedge clk);
        check_value("rden_cycle2", 32'(rden), 32'd1);
        check_value("raddr_cycle2", raddr, 32'h0);
        @(negedge clk);
        check_value("valid_cycle3", 32'(valid), 32'(EXP_VALID_C3));
        for (int i = 4; i <= 12; i++) begin
            @(negedge clk);
            check_value("valid_stream", 32'(valid), 32'd1);
        end
        check_value("wrap_pc0", hi_at(0), 32'hffff_fff8);
        check_value("wrap_pc1", hi_at(1), 32'hffff_fffc);
        check_value("wrap_pc2", hi_at(2), 32'h0000_0000);

        // Decode stalled: credit limit stops fetch at DEPTH requests
        ready = 1'b0;
        do_reset(1);
        repeat (20) @(negedge clk);
        check_value("full_accepts", 32'(acc_count), 32'd4);
        check_value("full_rden",    32'(rden),      32'd0);
        check_value("full_raddr",   raddr,          32'h10);
        @(posedge clk); #1;
        ready = 1'b1;
        repeat (12) @(negedge clk);
        for (int i = 0; i < 5; i++) check_value("drain_pc", log_at(i), 32'(i * 4));

        // Memory stall mid-stream
        do_reset(1);
        repeat (8) @(negedge clk);
        @(posedge clk); #1;
        mem_wait = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_value("wait_raddr", raddr, exp_raddr);
        end
        @(posedge clk); #1;
        mem_wait = 1'b0;
        repeat (10) @(negedge clk);
        for (int i = 0; i < 10; i++) check_value("wait_pc_seq", log_at(i), 32'(i * 4));

        // Redirect with several responses in flight, latency 3
        do_reset(3);
        repeat (12) @(negedge clk);
        begin
            int n = 0;
            while (pend.size() < 2 && n < 20) begin
                @(negedge clk);
                n++;
            end
            check_value("inflight_before_jmp", 32'(pend.size() >= 2), 32'd1);
        end
        @(posedge clk); #1;
        jmp_do = 1'b1;
        jmp_pc = 32'h0000_0103;
        pop_log.delete();
        @(negedge clk);
        check_value("jmp_valid", 32'(valid), 32'd0);
        check_value("jmp_rden",  32'(rden),  32'd0);
        @(posedge clk); #1;
        jmp_do = 1'b0;
        @(negedge clk);
        check_value("jmp_target_raddr", raddr, 32'h100);
        repeat (15) @(negedge clk);
        check_value("jmp_pc0", log_at(0), 32'h100);
        check_value("jmp_pc1", log_at(1), 32'h104);

        // Redirect coinciding with a response and a ready head, latency 1
        do_reset(1);
        repeat (10) @(negedge clk);
        check_value("pre_jmp_valid", 32'(valid), 32'd1);
        @(posedge clk); #1;
        jmp_do = 1'b1;
        jmp_pc = 32'h0000_0200;
        pop_log.delete();
        @(negedge clk);
        check_value("jmp2_valid", 32'(valid), 32'd0);
        @(posedge clk); #1;
        jmp_do = 1'b0;
        repeat (10) @(negedge clk);
        check_value("jmp2_pc0", log_at(0), 32'h200);
        check_value("jmp2_pc1", log_at(1), 32'h204);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
